// File: rtl/syncro_pkg.sv
// Shared defaults and helpers for the syncro_n_filt multi-channel input synchroniser.
package syncro_pkg;
    localparam int unsigned DEF_NUM_CH   = 2;
    localparam int unsigned DEF_STAGES   = 2;
    localparam int unsigned DEF_FILT_LEN = 4;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int unsigned num_ch, input int unsigned stages,
                                     input int unsigned filt_len);
        return (num_ch >= 1) && (stages >= 2) && (filt_len >= 1);
    endfunction
endpackage

// File: rtl/syncro_filt_ch.sv
// One channel: async flop chain, stability filter, filtered level and registered edge pulses.
module syncro_filt_ch
    import syncro_pkg::*;
#(
    parameter int unsigned STAGES    = DEF_STAGES,
    parameter int unsigned FILT_LEN  = DEF_FILT_LEN,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned   CW       = cnt_w(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          s;

    assign s = sync_q[STAGES-1];

    // Any return of s to the current level clears the count, so short glitches never commit.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d  = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            cnt_q  <= '0;
            out_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_i};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sig_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/syncro_n_filt.sv
// NUM_CH independent synchronise-and-filter channels plus a post-reset settled flag.
module syncro_n_filt
    import syncro_pkg::*;
#(
    parameter int unsigned       NUM_CH    = DEF_NUM_CH,
    parameter int unsigned       STAGES    = DEF_STAGES,
    parameter int unsigned       FILT_LEN  = DEF_FILT_LEN,
    parameter logic [NUM_CH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sig_in,
    output logic [NUM_CH-1:0] sig_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              settled
);
    localparam int unsigned   SETTLE_N    = STAGES + FILT_LEN;
    localparam int unsigned   SW          = $clog2(SETTLE_N + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_N);

    if (!params_ok(NUM_CH, STAGES, FILT_LEN)) begin : g_bad_params
        $error("syncro_n_filt: need NUM_CH>=1, STAGES>=2, FILT_LEN>=1");
    end

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        syncro_filt_ch #(
            .STAGES    (STAGES),
            .FILT_LEN  (FILT_LEN),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .sig_i  (sig_in[i]),
            .sig_o  (sig_out[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic          settled_q;

    always_comb begin
        set_cnt_d = set_cnt_q;
        if (set_cnt_q != SETTLE_LAST) begin
            set_cnt_d = set_cnt_q + SW'(1);
        end
    end

    // Flag rises on the same edge the counter lands on SETTLE_N, then both hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            set_cnt_q <= '0;
            settled_q <= 1'b0;
        end else begin
            set_cnt_q <= set_cnt_d;
            settled_q <= (set_cnt_d == SETTLE_LAST);
        end
    end

    assign settled = settled_q;
endmodule

// File: tb/tb_syncro_n_filt.sv
// Directed bench for syncro_n_filt: default build plus a 5-channel, 3-stage, unfiltered build.
module tb_syncro_n_filt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_reset;
    logic [1:0] d_sig_in, d_sig_out, d_rise, d_fall;
    logic       d_settled;

    logic       p_reset;
    logic [4:0] p_sig_in, p_sig_out, p_rise, p_fall;
    logic       p_settled;

    syncro_n_filt u_dut_d (
        .clk     (clk),
        .reset   (d_reset),
        .sig_in  (d_sig_in),
        .sig_out (d_sig_out),
        .rise    (d_rise),
        .fall    (d_fall),
        .settled (d_settled)
    );

    syncro_n_filt #(
        .NUM_CH    (5),
        .STAGES    (3),
        .FILT_LEN  (1),
        .RESET_VAL (5'b10101)
    ) u_dut_p (
        .clk     (clk),
        .reset   (p_reset),
        .sig_in  (p_sig_in),
        .sig_out (p_sig_out),
        .rise    (p_rise),
        .fall    (p_fall),
        .settled (p_settled)
    );

    typedef struct {
        string       tag;
        int unsigned cyc;
        bit          is_p;
        logic [4:0]  so;
        logic [4:0]  ri;
        logic [4:0]  fa;
        logic        st;
    } exp_t;

    exp_t        sb[$];
    int unsigned now    = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(input string tag, input string what, input logic [4:0] obs,
                       input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s cyc %0d observed %b expected %b", tag, what, now, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned dt, input bit is_p,
                        input logic [4:0] so, input logic [4:0] ri, input logic [4:0] fa,
                        input logic st);
        exp_t e;
        e.tag  = tag;
        e.cyc  = now + dt;
        e.is_p = is_p;
        e.so   = so;
        e.ri   = ri;
        e.fa   = fa;
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic exp_d(input string tag, input int unsigned dt, input logic [1:0] so,
                         input logic [1:0] ri, input logic [1:0] fa, input logic st);
        push(tag, dt, 1'b0, {3'b000, so}, {3'b000, ri}, {3'b000, fa}, st);
    endtask

    task automatic exp_p(input string tag, input int unsigned dt, input logic [4:0] so,
                         input logic [4:0] ri, input logic [4:0] fa, input logic st);
        push(tag, dt, 1'b1, so, ri, fa, st);
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire due expectations.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            now++;
            for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
                if (sb[i].cyc == now) begin
                    exp_t e;
                    e = sb[i];
                    if (e.is_p) begin
                        cmp(e.tag, "sig_out", p_sig_out, e.so);
                        cmp(e.tag, "rise", p_rise, e.ri);
                        cmp(e.tag, "fall", p_fall, e.fa);
                        cmp(e.tag, "settled", {4'b0000, p_settled}, {4'b0000, e.st});
                    end else begin
                        cmp(e.tag, "sig_out", {3'b000, d_sig_out}, e.so);
                        cmp(e.tag, "rise", {3'b000, d_rise}, e.ri);
                        cmp(e.tag, "fall", {3'b000, d_fall}, e.fa);
                        cmp(e.tag, "settled", {4'b0000, d_settled}, {4'b0000, e.st});
                    end
                    sb.delete(i);
                end
            end
        end
    endtask

    initial begin
        d_reset  = 1'b1;
        d_sig_in = 2'b00;
        p_reset  = 1'b1;
        p_sig_in = 5'b10101;

        // Reset held three cycles; sweep build shows its RESET_VAL.
        for (int t = 1; t <= 3; t++) begin
            exp_d("rst", t, 2'b00, 2'b00, 2'b00, 1'b0);
            exp_p("p_rst", t, 5'b10101, 5'b00000, 5'b00000, 1'b0);
        end
        tick(3);

        // Idle after release: settled exactly six cycles later.
        d_reset = 1'b0;
        for (int t = 1; t <= 8; t++)
            exp_d("settle", t, 2'b00, 2'b00, 2'b00, (t >= 6));
        tick(8);

        // Clean step on ch0.
        d_sig_in = 2'b01;
        for (int t = 1; t <= 8; t++)
            exp_d("step", t, (t >= 6) ? 2'b01 : 2'b00, (t == 6) ? 2'b01 : 2'b00, 2'b00, 1'b1);
        tick(8);

        // Three-cycle pulse on ch1 is rejected.
        d_sig_in = 2'b11;
        for (int t = 1; t <= 10; t++)
            exp_d("glitch3", t, 2'b01, 2'b00, 2'b00, 1'b1);
        tick(3);
        d_sig_in = 2'b01;
        tick(7);

        // Four-cycle pulse on ch1 passes, then falls after four stable-low cycles.
        d_sig_in = 2'b11;
        for (int t = 1; t <= 12; t++)
            exp_d("pulse4", t, (t >= 6 && t <= 9) ? 2'b11 : 2'b01,
                  (t == 6) ? 2'b10 : 2'b00, (t == 10) ? 2'b10 : 2'b00, 1'b1);
        tick(4);
        d_sig_in = 2'b01;
        tick(8);

        // Opposite edges on both channels in the same cycle.
        d_sig_in = 2'b10;
        for (int t = 1; t <= 8; t++)
            exp_d("simul", t, (t >= 6) ? 2'b10 : 2'b01,
                  (t == 6) ? 2'b10 : 2'b00, (t == 6) ? 2'b01 : 2'b00, 1'b1);
        tick(8);

        // ch0 step interrupted by reset mid-count; ch1 drops to reset value without a pulse.
        d_sig_in = 2'b11;
        for (int t = 1; t <= 4; t++)
            exp_d("midrst_pre", t, 2'b10, 2'b00, 2'b00, 1'b1);
        tick(4);
        d_reset = 1'b1;
        for (int t = 1; t <= 2; t++)
            exp_d("midrst_in", t, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(2);
        d_reset = 1'b0;
        for (int t = 1; t <= 8; t++)
            exp_d("midrst_post", t, (t >= 6) ? 2'b11 : 2'b00, (t == 6) ? 2'b11 : 2'b00,
                  2'b00, (t >= 6));
        tick(8);

        // Sweep build: release with matching inputs, no pulses, settled after four cycles.
        p_reset = 1'b0;
        for (int t = 1; t <= 6; t++)
            exp_p("p_release", t, 5'b10101, 5'b00000, 5'b00000, (t >= 4));
        tick(6);

        // All channels toggle: latency four, every channel pulses.
        p_sig_in = 5'b01010;
        for (int t = 1; t <= 6; t++)
            exp_p("p_toggle", t, (t >= 4) ? 5'b01010 : 5'b10101,
                  (t == 4) ? 5'b01010 : 5'b00000, (t == 4) ? 5'b10101 : 5'b00000, 1'b1);
        tick(6);

        // Unfiltered build passes a single-cycle input pulse through.
        p_sig_in = 5'b01011;
        for (int t = 1; t <= 7; t++)
            exp_p("p_glitch1", t, (t == 4) ? 5'b01011 : 5'b01010,
                  (t == 4) ? 5'b00001 : 5'b00000, (t == 5) ? 5'b00001 : 5'b00000, 1'b1);
        tick(1);
        p_sig_in = 5'b01010;
        tick(6);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
